// File: rtl/bus_src_pkg.sv
// Shared constants and types for the bus-source selector.
package bus_src_pkg;

    // Default opcodes for the two move instructions.
    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVT = 3'b001;

    // The non-register source codes sit directly above the register codes.
    function automatic int src_imm(input int num_reg);
        return num_reg;
    endfunction

    function automatic int src_din(input int num_reg);
        return num_reg + 1;
    endfunction

    function automatic int src_g(input int num_reg);
        return num_reg + 2;
    endfunction

    // Occupancy of the output register plus skid entry.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } store_state_t;

endpackage

// File: rtl/bus_src_mux_pipe_imm_fmt.sv
// Formats the immediate carried in the instruction register for the bus.
module imm_fmt
    import bus_src_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int IMM_W = 9,
    parameter int OPC_W = 3,
    parameter logic [OPC_W-1:0] OP_MV = OPC_W'(bus_src_pkg::OP_MV),
    parameter logic [OPC_W-1:0] OP_MVT = OPC_W'(bus_src_pkg::OP_MVT),
    parameter bit SEXT_IMM = 1'b0
) (
    input  logic [DATA_W-1:0] ir,
    output logic [DATA_W-1:0] imm
);

    localparam int HALF_W = DATA_W / 2;

    logic [OPC_W-1:0] op;
    logic             unused_ir;

    assign op = ir[DATA_W-1 -: OPC_W];

    // Bits between the fields are never looked at by any format.
    assign unused_ir = ^ir;

    // MV: low-aligned IMM_W field; MVT: low half moved to the top; else low half.
    always_comb begin
        imm = '0;
        if (op == OP_MV) begin
            imm[IMM_W-1:0] = ir[IMM_W-1:0];
            if (SEXT_IMM) begin
                imm[DATA_W-1:IMM_W] = {(DATA_W-IMM_W){ir[IMM_W-1]}};
            end
        end else if (op == OP_MVT) begin
            imm = {ir[HALF_W-1:0], {HALF_W{1'b0}}};
        end else begin
            imm[HALF_W-1:0] = ir[HALF_W-1:0];
        end
    end

endmodule

// File: rtl/bus_src_mux_pipe.sv
// Registered bus-source selector with a two-entry (output + skid) buffer.
//
// Handshake: an input transfer happens on a rising edge where
// sel_valid & sel_ready; an output transfer happens where
// bus_valid & bus_ready. sel_ready depends on stored state only, so the
// control FSM never sees a combinational path from bus_ready.
module bus_src_mux_pipe
    import bus_src_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int NUM_REG = 8,
    parameter int IMM_W = 9,
    parameter int OPC_W = 3,
    parameter logic [OPC_W-1:0] OP_MV = OPC_W'(bus_src_pkg::OP_MV),
    parameter logic [OPC_W-1:0] OP_MVT = OPC_W'(bus_src_pkg::OP_MVT),
    parameter bit SEXT_IMM = 1'b0,
    parameter int SEL_W = $clog2(NUM_REG + 3)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REG*DATA_W-1:0] reg_data,
    input  logic [DATA_W-1:0]         ir,
    input  logic [DATA_W-1:0]         din,
    input  logic [DATA_W-1:0]         g_data,
    input  logic                      sel_valid,
    input  logic [SEL_W-1:0]          sel,
    output logic                      sel_ready,
    output logic [DATA_W-1:0]         bus_out,
    output logic                      bus_valid,
    input  logic                      bus_ready,
    output logic                      err_sel
);

    localparam logic [SEL_W-1:0] SEL_IMM = SEL_W'(src_imm(NUM_REG));
    localparam logic [SEL_W-1:0] SEL_DIN = SEL_W'(src_din(NUM_REG));
    localparam logic [SEL_W-1:0] SEL_G   = SEL_W'(src_g(NUM_REG));

    store_state_t      state;
    store_state_t      state_next;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] src_word;
    logic              src_ok;
    logic              accept;
    logic              push;
    logic              pop;
    logic              load_out_src;
    logic              load_out_skid;
    logic              load_skid;
    logic [DATA_W-1:0] out_q;
    logic [DATA_W-1:0] skid_q;
    logic              err_q;

    imm_fmt #(
        .DATA_W  (DATA_W),
        .IMM_W   (IMM_W),
        .OPC_W   (OPC_W),
        .OP_MV   (OP_MV),
        .OP_MVT  (OP_MVT),
        .SEXT_IMM(SEXT_IMM)
    ) u_imm_fmt (
        .ir (ir),
        .imm(imm)
    );

    // Pick the source word from the live inputs; flag codes past the last source.
    always_comb begin
        src_word = '0;
        src_ok   = 1'b1;
        if (sel == SEL_IMM) begin
            src_word = imm;
        end else if (sel == SEL_DIN) begin
            src_word = din;
        end else if (sel == SEL_G) begin
            src_word = g_data;
        end else begin
            src_ok = 1'b0;
            for (int i = 0; i < NUM_REG; i++) begin
                if (sel == SEL_W'(i)) begin
                    src_word = reg_data[i*DATA_W +: DATA_W];
                    src_ok   = 1'b1;
                end
            end
        end
    end

    assign accept = sel_valid & sel_ready;
    assign push   = accept & src_ok;
    assign pop    = bus_valid & bus_ready;

    // Storage state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Occupancy transitions driven by push and pop.
    always_comb begin
        state_next = state;
        case (state)
            EMPTY: if (push) state_next = ONE;
            ONE: begin
                if (push && !pop) begin
                    state_next = TWO;
                end else if (!push && pop) begin
                    state_next = EMPTY;
                end
            end
            TWO: if (pop) state_next = ONE;
            default: state_next = EMPTY;
        endcase
    end

    // Handshake outputs and datapath load enables decoded from state.
    always_comb begin
        bus_valid     = (state != EMPTY);
        sel_ready     = (state != TWO);
        load_out_src  = 1'b0;
        load_out_skid = 1'b0;
        load_skid     = 1'b0;
        case (state)
            EMPTY: load_out_src = push;
            ONE: begin
                load_out_src = push & pop;
                load_skid    = push & ~pop;
            end
            TWO: load_out_skid = pop;
            default: ;
        endcase
    end

    // Output register, skid entry and the error pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_q  <= '0;
            skid_q <= '0;
            err_q  <= 1'b0;
        end else begin
            err_q <= accept & ~src_ok;
            if (load_out_src) begin
                out_q <= src_word;
            end else if (load_out_skid) begin
                out_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= src_word;
            end
        end
    end

    assign bus_out = out_q;
    assign err_sel = err_q;

endmodule

// File: tb/tb_bus_src_mux_pipe.sv
// Directed bench for bus_src_mux_pipe, with a second instance built with
// sign-extended MV immediates sharing the same stimulus.
module tb_bus_src_mux_pipe;

    localparam int DATA_W  = 16;
    localparam int NUM_REG = 8;
    localparam int SEL_W   = 4;

    logic                      clk;
    logic                      reset;
    logic [NUM_REG*DATA_W-1:0] reg_data;
    logic [DATA_W-1:0]         ir;
    logic [DATA_W-1:0]         din;
    logic [DATA_W-1:0]         g_data;
    logic                      sel_valid;
    logic [SEL_W-1:0]          sel;
    logic                      sel_ready;
    logic [DATA_W-1:0]         bus_out;
    logic                      bus_valid;
    logic                      bus_ready;
    logic                      err_sel;

    logic                      sel_ready_s;
    logic [DATA_W-1:0]         bus_out_s;
    logic                      bus_valid_s;
    logic                      err_sel_s;

    int checks = 0;
    int errors = 0;
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] exp_w;

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    bus_src_mux_pipe dut (
        .clk(clk), .reset(reset), .reg_data(reg_data), .ir(ir), .din(din),
        .g_data(g_data), .sel_valid(sel_valid), .sel(sel), .sel_ready(sel_ready),
        .bus_out(bus_out), .bus_valid(bus_valid), .bus_ready(bus_ready),
        .err_sel(err_sel)
    );

    bus_src_mux_pipe #(.SEXT_IMM(1'b1)) dut_s (
        .clk(clk), .reset(reset), .reg_data(reg_data), .ir(ir), .din(din),
        .g_data(g_data), .sel_valid(sel_valid), .sel(sel), .sel_ready(sel_ready_s),
        .bus_out(bus_out_s), .bus_valid(bus_valid_s), .bus_ready(bus_ready),
        .err_sel(err_sel_s)
    );

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_reg(input int idx, input logic [DATA_W-1:0] val);
        reg_data[idx*DATA_W +: DATA_W] = val;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        reset     = 1'b1;
        reg_data  = '0;
        ir        = '0;
        din       = '0;
        g_data    = '0;
        sel_valid = 1'b0;
        sel       = '0;
        bus_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // reset state
        chk("rst_bus_valid", 32'(bus_valid), 32'd0);
        chk("rst_bus_out", 32'(bus_out), 32'h0);
        chk("rst_err_sel", 32'(err_sel), 32'd0);
        chk("rst_sel_ready", 32'(sel_ready), 32'd1);

        // single register word, consumed immediately
        set_reg(3, 16'hBEEF);
        sel = 4'd3; sel_valid = 1'b1; bus_ready = 1'b1;
        tick();
        chk("r3_valid", 32'(bus_valid), 32'd1);
        chk("r3_data", 32'(bus_out), 32'hBEEF);
        chk("r3_sel_ready", 32'(sel_ready), 32'd1);
        sel_valid = 1'b0;
        tick();
        chk("r3_drained", 32'(bus_valid), 32'd0);
        chk("r3_hold", 32'(bus_out), 32'hBEEF);

        // immediate formats, back-to-back with the consumer ready
        sel = 4'd8; sel_valid = 1'b1; ir = 16'h01A5;
        tick();
        chk("imm_mv_zext", 32'(bus_out), 32'h01A5);
        chk("imm_mv_sext", 32'(bus_out_s), 32'hFFA5);
        ir = 16'h21A5;
        tick();
        chk("imm_mvt", 32'(bus_out), 32'hA500);
        chk("imm_mvt_s", 32'(bus_out_s), 32'hA500);
        ir = 16'h41A5;
        tick();
        chk("imm_other", 32'(bus_out), 32'h00A5);
        chk("imm_other_valid", 32'(bus_valid), 32'd1);
        sel_valid = 1'b0;
        tick();
        chk("imm_drained", 32'(bus_valid), 32'd0);

        // stall: two words fill output and skid, third is refused
        bus_ready = 1'b0;
        set_reg(0, 16'h0001); set_reg(1, 16'h0002); set_reg(2, 16'h0003);
        sel = 4'd0; sel_valid = 1'b1;
        tick();
        chk("stall1_ready", 32'(sel_ready), 32'd1);
        chk("stall1_data", 32'(bus_out), 32'h0001);
        sel = 4'd1;
        tick();
        chk("stall2_ready", 32'(sel_ready), 32'd0);
        chk("stall2_valid", 32'(bus_valid), 32'd1);
        chk("stall2_data", 32'(bus_out), 32'h0001);
        sel = 4'd2;
        tick();
        chk("stall3_data", 32'(bus_out), 32'h0001);
        chk("stall3_ready", 32'(sel_ready), 32'd0);
        sel_valid = 1'b0;
        bus_ready = 1'b1;
        tick();
        chk("drain_second", 32'(bus_out), 32'h0002);
        chk("drain_ready", 32'(sel_ready), 32'd1);
        tick();
        chk("drain_empty", 32'(bus_valid), 32'd0);
        chk("drain_hold", 32'(bus_out), 32'h0002);

        // back-to-back through every valid source code 0..9
        for (int i = 0; i < NUM_REG; i++) set_reg(i, 16'(16'h1000 + i));
        ir  = 16'h01A5;
        din = 16'hD00D;
        sel_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            sel = SEL_W'(c);
            if (c < NUM_REG) exp_q.push_back(16'(16'h1000 + c));
            else if (c == NUM_REG) exp_q.push_back(16'h01A5);
            else exp_q.push_back(16'hD00D);
            tick();
            exp_w = exp_q.pop_front();
            chk("b2b_data", 32'(bus_out), 32'(exp_w));
            chk("b2b_valid", 32'(bus_valid), 32'd1);
            chk("b2b_ready", 32'(sel_ready), 32'd1);
        end
        sel_valid = 1'b0;
        tick();
        chk("b2b_drained", 32'(bus_valid), 32'd0);

        // ALU result source
        g_data = 16'hCAFE;
        sel = 4'd10; sel_valid = 1'b1;
        tick();
        chk("g_data", 32'(bus_out), 32'hCAFE);
        sel_valid = 1'b0;
        tick();
        chk("g_drained", 32'(bus_valid), 32'd0);

        // out-of-range select: error pulse only
        sel = 4'd15; sel_valid = 1'b1;
        tick();
        chk("err_pulse", 32'(err_sel), 32'd1);
        chk("err_valid", 32'(bus_valid), 32'd0);
        chk("err_data", 32'(bus_out), 32'hCAFE);
        sel_valid = 1'b0;
        tick();
        chk("err_clear", 32'(err_sel), 32'd0);
        chk("err_data2", 32'(bus_out), 32'hCAFE);

        // reset while full discards both words
        bus_ready = 1'b0;
        sel = 4'd0; sel_valid = 1'b1;
        tick();
        sel = 4'd1;
        tick();
        chk("full_ready", 32'(sel_ready), 32'd0);
        reset = 1'b1; sel_valid = 1'b0;
        tick();
        chk("rst2_valid", 32'(bus_valid), 32'd0);
        chk("rst2_data", 32'(bus_out), 32'h0);
        chk("rst2_ready", 32'(sel_ready), 32'd1);
        reset = 1'b0;
        din = 16'h1234;
        sel = 4'd9; sel_valid = 1'b1; bus_ready = 1'b1;
        tick();
        chk("din_data", 32'(bus_out), 32'h1234);
        chk("din_valid", 32'(bus_valid), 32'd1);
        sel_valid = 1'b0;
        tick();
        chk("din_drained", 32'(bus_valid), 32'd0);

        // final report
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_src_mux_pipe.md
Name: bus_src_mux_pipe

Overview:
- Parametrised, registered bus-source selector for the simple processor datapath.
- Picks one of NUM_REG register outputs, the IR-derived immediate, memory din, or the ALU result G, and drives it onto the shared bus.
- Uses a valid/ready handshake and a two-entry skid buffer, so the control FSM can issue a select every cycle while the bus consumer stalls.
- Source data is captured at acceptance time, not when the consumer takes it.

Parameters:
- DATA_W, 16, bus and source word width (even, >=8)
- NUM_REG, 8, number of register-file sources (>=1)
- IMM_W, 9, immediate field width for MV (IMM_W < DATA_W-OPC_W)
- OPC_W, 3, opcode field width, located at ir[DATA_W-1 -: OPC_W]
- OP_MV, 3'b000, opcode for move-immediate (low-aligned)
- OP_MVT, 3'b001, opcode for move-top (high-aligned)
- SEXT_IMM, 0, 1 = MV immediate sign-extended, 0 = zero-extended
- SEL_W, $clog2(NUM_REG+3), select width (derived; do not override)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- reg_data  in  NUM_REG*DATA_W  packed register outputs; R[i] = reg_data[i*DATA_W +: DATA_W]
- ir  in  DATA_W  instruction register
- din  in  DATA_W  memory read data
- g_data  in  DATA_W  ALU result register G
- sel_valid  in  1  select request valid
- sel  in  SEL_W  source code: 0..NUM_REG-1 = R[i]; NUM_REG = IMM; NUM_REG+1 = DIN; NUM_REG+2 = G
- sel_ready  out  1  block can accept a select this cycle
- bus_out  out  DATA_W  bus word
- bus_valid  out  1  bus_out holds an unconsumed word
- bus_ready  in  1  consumer takes bus_out this cycle
- err_sel  out  1  one-cycle pulse: an accepted sel was out of range

Behaviour:
- Reset values: bus_out=0, bus_valid=0, err_sel=0, skid empty, sel_ready=1.
- Reset overrides everything in the same cycle; in-flight words are discarded.
- Accept = sel_valid & sel_ready.
- On accept, the word is formed combinationally from the current inputs.
- Immediate formatting, selected by op = ir[DATA_W-1 -: OPC_W]:
  - op==OP_MV: ir[IMM_W-1:0], zero- or sign-extended per SEXT_IMM.
  - op==OP_MVT: {ir[DATA_W/2-1:0], DATA_W/2 zeros}.
  - Any other op: zero-extended ir[DATA_W/2-1:0].
- Out-of-range sel (>= NUM_REG+3):
  - Accepted, but no word is enqueued.
  - err_sel=1 on the next cycle; bus state unchanged.
- Latency: word accepted at edge k appears with bus_valid=1 after edge k. One-cycle latency when the output is empty or draining.
- Storage states:
  - EMPTY: bus_valid=0, sel_ready=1.
  - ONE: bus_valid=1, skid empty, sel_ready=1.
  - TWO: bus_valid=1, skid full, sel_ready=0.
- Transitions, where pop = bus_valid & bus_ready and push = valid accept:
  - EMPTY + push -> ONE (load output register).
  - ONE + push & !pop -> TWO (word goes to skid).
  - ONE + push & pop -> ONE (output register reloaded with the new word).
  - ONE + !push & pop -> EMPTY.
  - TWO + pop -> ONE (skid moves to output; no push is possible since sel_ready=0).
  - Otherwise hold.
- Ordering: words leave strictly in acceptance order.
- Hold rule: bus_out holds its last value while bus_valid=0 or bus_ready=0; it never goes to X or zero after a pop.
- sel_ready is a registered function of state only; no combinational path from bus_ready to sel_ready.
- bus_ready while bus_valid=0 is ignored.

Decomposition:
- Package bus_src_pkg:
  - Source-code constants SRC_IMM, SRC_DIN, SRC_G as functions of NUM_REG.
  - Default opcode constants OP_MV, OP_MVT.
  - A storage-state enum {EMPTY, ONE, TWO}.
- Sub-module imm_fmt (combinational): ir -> formatted immediate, parametrised by DATA_W, IMM_W, OPC_W, SEXT_IMM. Unit-tested separately.
- Top level: source select, skid buffer and FSM.

Test Plan:
- Reset, then sel=3 with R3=16'hBEEF and bus_ready=1 -> bus_out=16'hBEEF, bus_valid=1 one cycle after accept; EMPTY->ONE->EMPTY.
- IMM, ir=16'h01A5 (op MV, SEXT_IMM=0) -> 16'h01A5; ir=16'h21A5 (op MVT) -> 16'hA500; ir=16'h41A5 -> 16'h00A5. Rerun with SEXT_IMM=1 and ir=16'h01A5 -> 16'hFFA5.
- Stall: bus_ready=0, issue sel=0 (R0=1) then sel=1 (R1=2):
  - sel_ready=0 after the second accept; a third sel_valid is not accepted.
  - Raise bus_ready -> outputs 1 then 2, in order.
- Back-to-back: sel_valid=1 for 10 cycles with bus_ready=1 and sel cycling 0..9 -> one word per cycle, sel_ready never drops.
- sel=4'd15 accepted -> err_sel pulse for exactly one cycle, bus_valid and bus_out unchanged.
- Reset asserted in state TWO -> next cycle bus_valid=0, bus_out=0, sel_ready=1; subsequent sel=NUM_REG+1 with din=16'h1234 -> 16'h1234.
